aes_ct_collector: RTL and testbench

- Downstream stage of the byte-serial AES core.
- Captures the 16-byte ciphertext the core emits on 16 consecutive clocks once its data-valid rises, and holds it in a buffer.
- Presents the buffer one byte at a time on the output pins. The host steps through it with a slow, pin-driven read strobe, so ciphertext survives after the core's output stream ends.

---
 rtl/aes_ct_collector_if.sv | 33 +++
 rtl/aes_ct_collector.sv | 217 +++++++++++++++++++++
 tb/tb_aes_ct_collector.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_ct_collector_if.sv
// -----------------------------------------------------------------------------
// aes_ct_collector_if
// Signal bundle between the AES ciphertext collector and its surroundings.
//   master : drives ct_valid/ct_byte (core stream), rd_strobe and clear
//            (host side); observes dout, dout_valid, byte_idx, busy, done, ovf.
//   slave  : the collector itself (the mirror image of master).
// -----------------------------------------------------------------------------
interface aes_ct_collector_if #(
   parameter int NBYTES = 16
);
   localparam int PW = $clog2(NBYTES);

   logic          ct_valid;
   logic [7:0]    ct_byte;
   logic          rd_strobe;
   logic          clear;
   logic [7:0]    dout;
   logic          dout_valid;
   logic [PW-1:0] byte_idx;
   logic          busy;
   logic          done;
   logic          ovf;

   modport master (
      output ct_valid, ct_byte, rd_strobe, clear,
      input  dout, dout_valid, byte_idx, busy, done, ovf
   );

   modport slave (
      input  ct_valid, ct_byte, rd_strobe, clear,
      output dout, dout_valid, byte_idx, busy, done, ovf
   );
endinterface

// File: rtl/aes_ct_collector.sv
// -----------------------------------------------------------------------------
// aes_ct_collector
// Captures the NBYTES-byte ciphertext burst that the byte-serial AES core emits
// after its data-valid rises, then lets a slow host step through the buffered
// bytes with a pin-level read strobe.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : ct_valid/ct_byte core stream, rd_strobe host advance,
//                        clear synchronous abort; dout/byte_idx current byte,
//                        dout_valid unread data present, busy capture running,
//                        done one-cycle end-of-drain pulse, ovf sticky overrun
// -----------------------------------------------------------------------------
module aes_ct_collector #(
   parameter int NBYTES  = 16,
   parameter bit SYNC_RD = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   aes_ct_collector_if.slave  bus
);
   localparam int            PW   = $clog2(NBYTES);
   localparam logic [PW-1:0] LAST = PW'(NBYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_READY   = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic [PW-1:0] wr_ptr_r, wr_ptr_s;
   logic [PW-1:0] rd_ptr_r, rd_ptr_s;
   logic [7:0]    ct_buf_r [NBYTES];
   logic          buf_we_s;
   logic [PW-1:0] buf_wa_s;
   logic          ct_valid_q_r;
   logic          rd_lvl_s;
   logic          rd_q_r;
   logic          ct_rise_s;
   logic          rd_rise_s;
   logic [7:0]    dout_r, dout_s;
   logic          dout_valid_r, dout_valid_s;
   logic [PW-1:0] byte_idx_r, byte_idx_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic          ovf_r, ovf_s;

   // rd_strobe is a host pin and may be asynchronous to clk.
   generate
      if (SYNC_RD) begin : g_sync
         logic rd_meta_r;
         logic rd_sync_r;
         // Two-flop synchronizer for the host read strobe.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rd_meta_r <= 1'b0;
               rd_sync_r <= 1'b0;
            end else begin
               rd_meta_r <= bus.rd_strobe;
               rd_sync_r <= rd_meta_r;
            end
         end
         assign rd_lvl_s = rd_sync_r;
      end else begin : g_raw
         assign rd_lvl_s = bus.rd_strobe;
      end
   endgenerate

   // Delayed copies of ct_valid and the read level for rising-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ct_valid_q_r <= 1'b0;
         rd_q_r       <= 1'b0;
      end else begin
         ct_valid_q_r <= bus.ct_valid;
         rd_q_r       <= rd_lvl_s;
      end
   end

   assign ct_rise_s = bus.ct_valid & ~ct_valid_q_r;
   assign rd_rise_s = rd_lvl_s & ~rd_q_r;

   // Next-state and next-output logic; clear overrides every event.
   always_comb begin
      state_s      = state_r;
      wr_ptr_s     = wr_ptr_r;
      rd_ptr_s     = rd_ptr_r;
      dout_s       = dout_r;
      dout_valid_s = dout_valid_r;
      byte_idx_s   = byte_idx_r;
      busy_s       = busy_r;
      done_s       = 1'b0;
      ovf_s        = ovf_r;
      buf_we_s     = 1'b0;
      buf_wa_s     = wr_ptr_r;

      if (bus.clear) begin
         state_s      = ST_IDLE;
         wr_ptr_s     = {PW{1'b0}};
         rd_ptr_s     = {PW{1'b0}};
         dout_s       = 8'h00;
         dout_valid_s = 1'b0;
         byte_idx_s   = {PW{1'b0}};
         busy_s       = 1'b0;
         ovf_s        = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ct_rise_s) begin
                  buf_we_s = 1'b1;
                  buf_wa_s = {PW{1'b0}};
                  wr_ptr_s = PW'(1);
                  busy_s   = 1'b1;
                  state_s  = ST_CAPTURE;
               end else begin
                  state_s  = ST_IDLE;
               end
            end
            ST_CAPTURE: begin
               // Fixed-timing stream: ct_valid level is irrelevant here, only
               // a fresh rising edge matters (and it is an overrun).
               buf_we_s = 1'b1;
               buf_wa_s = wr_ptr_r;
               if (ct_rise_s) begin
                  ovf_s = 1'b1;
               end else begin
                  ovf_s = ovf_r;
               end
               if (wr_ptr_r == LAST) begin
                  // Byte 0 was stored long ago, so it can be presented on the
                  // same edge that ends the capture.
                  state_s      = ST_READY;
                  wr_ptr_s     = {PW{1'b0}};
                  rd_ptr_s     = {PW{1'b0}};
                  busy_s       = 1'b0;
                  dout_s       = ct_buf_r[0];
                  byte_idx_s   = {PW{1'b0}};
                  dout_valid_s = 1'b1;
               end else begin
                  wr_ptr_s     = wr_ptr_r + PW'(1);
               end
            end
            ST_READY: begin
               if (ct_rise_s) begin
                  ovf_s = 1'b1;
               end else begin
                  ovf_s = ovf_r;
               end
               if (rd_rise_s && (rd_ptr_r == LAST)) begin
                  state_s      = ST_IDLE;
                  rd_ptr_s     = {PW{1'b0}};
                  dout_s       = 8'h00;
                  dout_valid_s = 1'b0;
                  byte_idx_s   = {PW{1'b0}};
                  done_s       = 1'b1;
               end else if (rd_rise_s) begin
                  // dout follows rd_ptr one cycle later.
                  rd_ptr_s     = rd_ptr_r + PW'(1);
                  dout_s       = ct_buf_r[rd_ptr_r];
                  byte_idx_s   = rd_ptr_r;
                  dout_valid_s = 1'b1;
               end else begin
                  dout_s       = ct_buf_r[rd_ptr_r];
                  byte_idx_s   = rd_ptr_r;
                  dout_valid_s = 1'b1;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state, pointers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         wr_ptr_r     <= {PW{1'b0}};
         rd_ptr_r     <= {PW{1'b0}};
         dout_r       <= 8'h00;
         dout_valid_r <= 1'b0;
         byte_idx_r   <= {PW{1'b0}};
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         ovf_r        <= 1'b0;
      end else begin
         state_r      <= state_s;
         wr_ptr_r     <= wr_ptr_s;
         rd_ptr_r     <= rd_ptr_s;
         dout_r       <= dout_s;
         dout_valid_r <= dout_valid_s;
         byte_idx_r   <= byte_idx_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
         ovf_r        <= ovf_s;
      end
   end

   // Ciphertext buffer; contents survive clear, only reset wipes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NBYTES; i++) begin
            ct_buf_r[i] <= 8'h00;
         end
      end else if (buf_we_s) begin
         ct_buf_r[buf_wa_s] <= bus.ct_byte;
      end
   end

   assign bus.dout       = dout_r;
   assign bus.dout_valid = dout_valid_r;
   assign bus.byte_idx   = byte_idx_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.ovf        = ovf_r;
endmodule

// File: tb/tb_aes_ct_collector.sv
// -----------------------------------------------------------------------------
// tb_aes_ct_collector
// Self-checking bench for aes_ct_collector (NBYTES=16, SYNC_RD=1). A block-level
// model (buffer copy, read index, valid and overrun flags) predicts what the
// host should see after each stream, read pulse, clear or reset.
// -----------------------------------------------------------------------------
module tb_aes_ct_collector;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_ct_collector_if #(.NBYTES(16)) bus ();

   aes_ct_collector #(.NBYTES(16), .SYNC_RD(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int busy_cnt = 0;

   logic [7:0] s_bytes [16];
   logic [7:0] fips [16] = '{8'h39, 8'h25, 8'h84, 8'h1d, 8'h02, 8'hdc, 8'h09, 8'hfb,
                             8'hdc, 8'h11, 8'h85, 8'h97, 8'h19, 8'h6a, 8'h0b, 8'h32};

   // Reference model state
   logic [7:0] m_buf [16];
   bit         m_valid = 1'b0;
   int         m_idx   = 0;
   bit         m_ovf   = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".dout"},       32'(bus.dout),       m_valid ? 32'(m_buf[m_idx]) : 32'h0);
      check_val({tag, ".dout_valid"}, 32'(bus.dout_valid), 32'(m_valid));
      check_val({tag, ".byte_idx"},   32'(bus.byte_idx),   m_valid ? 32'(m_idx) : 32'h0);
      check_val({tag, ".busy"},       32'(bus.busy),       32'h0);
      check_val({tag, ".ovf"},        32'(bus.ovf),        32'(m_ovf));
   endtask

   // Model: one host read step; returns whether done should pulse.
   task automatic m_read(output bit fin);
      fin = 1'b0;
      if (m_valid) begin
         if (m_idx == 15) begin
            m_valid = 1'b0;
            m_idx   = 0;
            fin     = 1'b1;
         end else begin
            m_idx++;
         end
      end
   endtask

   // Drive a 16-byte burst from s_bytes; ct_valid drops from byte 'drop' on.
   task automatic send_stream(input string tag, input int drop, input bit force_ovr);
      int  b0;
      bit  capture;
      capture = !(m_valid || force_ovr);
      b0 = busy_cnt;
      bus.ct_valid = 1'b1;
      bus.ct_byte  = s_bytes[0];
      for (int k = 1; k < 16; k++) begin
         tick();
         bus.ct_byte = s_bytes[k];
         if (k >= drop) bus.ct_valid = 1'b0;
      end
      tick();
      bus.ct_valid = 1'b0;
      bus.ct_byte  = 8'h00;
      if (capture) begin
         m_buf   = s_bytes;
         m_valid = 1'b1;
         m_idx   = 0;
      end else begin
         m_ovf = 1'b1;
      end
      check_val({tag, ".busy_cycles"}, 32'(busy_cnt - b0), capture ? 32'd15 : 32'd0);
      check_outputs(tag);
      tick();
   endtask

   task automatic read_pulse(input string tag, input int hi, input int lo, input bit lat);
      int d0;
      int old;
      bit fin;
      bit do_lat;
      d0 = done_cnt;
      old = m_idx;
      do_lat = lat && m_valid && (m_idx < 15);
      bus.rd_strobe = 1'b1;
      for (int t = 1; t <= hi; t++) begin
         tick();
         if (do_lat && t == 3) check_val({tag, ".idx_edge3"}, 32'(bus.byte_idx), 32'(old));
         if (do_lat && t == 4) check_val({tag, ".idx_edge4"}, 32'(bus.byte_idx), 32'(old + 1));
      end
      bus.rd_strobe = 1'b0;
      repeat (lo) tick();
      m_read(fin);
      check_val({tag, ".done"}, 32'(done_cnt - d0), 32'(fin));
      check_outputs(tag);
   endtask

   task automatic do_clear(input string tag);
      int d0;
      d0 = done_cnt;
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      tick();
      m_valid = 1'b0;
      m_idx   = 0;
      m_ovf   = 1'b0;
      check_val({tag, ".done"}, 32'(done_cnt - d0), 32'h0);
      check_outputs(tag);
   endtask

   initial begin
      bit fin;
      int d0;
      int b0;
      bus.ct_valid  = 1'b0;
      bus.ct_byte   = 8'h00;
      bus.rd_strobe = 1'b0;
      bus.clear     = 1'b0;

      // Reset values
      #12;
      check_outputs("reset");
      check_val("reset.done", 32'(bus.done), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Basic capture of FIPS-197 ciphertext and full drain
      s_bytes = fips;
      send_stream("fips_cap", 16, 1'b0);
      check_val("fips_cap.byte0", 32'(bus.dout), 32'h39);
      for (int i = 0; i < 16; i++) read_pulse("fips_drain", 4, 4, i < 15);
      check_val("fips_drain.valid_end", 32'(bus.dout_valid), 32'h0);

      // Held strobe advances exactly once
      for (int i = 0; i < 16; i++) s_bytes[i] = 8'($urandom);
      send_stream("held_cap", 16, 1'b0);
      bus.rd_strobe = 1'b1;
      repeat (50) tick();
      bus.rd_strobe = 1'b0;
      repeat (4) tick();
      m_read(fin);
      check_outputs("held");
      check_val("held.idx", 32'(bus.byte_idx), 32'd1);
      do_clear("held_clr");

      // Overrun while READY at index 5
      for (int i = 0; i < 16; i++) s_bytes[i] = 8'($urandom);
      send_stream("ovr_cap", 16, 1'b0);
      for (int i = 0; i < 5; i++) read_pulse("ovr_step", 2, 4, 1'b0);
      for (int i = 0; i < 16; i++) s_bytes[i] = 8'($urandom);
      send_stream("ovr_hit", 16, 1'b0);
      check_val("ovr_hit.ovf", 32'(bus.ovf), 32'h1);
      read_pulse("ovr_after", 3, 4, 1'b0);
      do_clear("ovr_clr");

      // Clear coincident with ct_rise from IDLE
      b0 = busy_cnt;
      bus.clear    = 1'b1;
      bus.ct_valid = 1'b1;
      bus.ct_byte  = 8'haa;
      tick();
      bus.clear = 1'b0;
      repeat (15) tick();
      bus.ct_valid = 1'b0;
      tick();
      check_val("clr_prio.busy_cycles", 32'(busy_cnt - b0), 32'h0);
      check_outputs("clr_prio");

      // ct_valid drops at byte 7; all 16 bytes still captured
      for (int i = 0; i < 16; i++) s_bytes[i] = 8'($urandom);
      send_stream("drop7", 7, 1'b0);
      for (int i = 0; i < 15; i++) read_pulse("drop7_drain", 4, 4, 1'b0);

      // Final read coincident with a new ct_rise: overrun, not captured
      d0 = done_cnt;
      bus.rd_strobe = 1'b1;
      tick();
      tick();
      m_read(fin);
      for (int i = 0; i < 16; i++) s_bytes[i] = 8'($urandom);
      send_stream("coinc", 16, 1'b1);
      bus.rd_strobe = 1'b0;
      repeat (4) tick();
      check_val("coinc.done", 32'(done_cnt - d0), 32'h1);
      check_outputs("coinc_end");

      // Asynchronous reset mid-capture
      for (int i = 0; i < 16; i++) s_bytes[i] = 8'($urandom);
      bus.ct_valid = 1'b1;
      bus.ct_byte  = s_bytes[0];
      for (int k = 1; k <= 8; k++) begin
         tick();
         bus.ct_byte = s_bytes[k];
      end
      check_val("arst.busy_before", 32'(bus.busy), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      m_valid = 1'b0;
      m_idx   = 0;
      m_ovf   = 1'b0;
      check_outputs("arst");
      check_val("arst.done", 32'(bus.done), 32'h0);
      #1;
      bus.ct_valid = 1'b0;
      bus.ct_byte  = 8'h00;
      rst_n = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 16; i++) s_bytes[i] = 8'(i);
      send_stream("arst_fresh", 16, 1'b0);
      for (int i = 0; i < 16; i++) read_pulse("arst_drain", 4, 4, 1'b0);

      // Randomized operation mix
      for (int n = 0; n < 60; n++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op <= 2) begin
            for (int i = 0; i < 16; i++) s_bytes[i] = 8'($urandom);
            send_stream("rnd_stream", $urandom_range(1, 16), 1'b0);
         end else if (op <= 7) begin
            read_pulse("rnd_read", $urandom_range(1, 5), $urandom_range(4, 6), 1'b0);
         end else if (op == 8) begin
            do_clear("rnd_clear");
         end else begin
            repeat ($urandom_range(1, 5)) tick();
            check_outputs("rnd_idle");
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
